// File: rtl/vga_img_pipe_if.sv
// Pixel-path bundle for vga_img_pipe: timing-generator inputs, image ROM port
// and VGA pin outputs. master = timing/ROM/pin side, slave = the pipeline.
interface vga_img_pipe_if;
    logic [10:0] x_in;
    logic [10:0] y_in;
    logic        de_in;
    logic        hsync_in;
    logic        vsync_in;
    logic [16:0] rom_addr;
    logic [3:0]  rom_data;
    logic [4:0]  vga_r;
    logic [5:0]  vga_g;
    logic [4:0]  vga_b;
    logic        vga_hsync;
    logic        vga_vsync;

    modport master (
        output x_in, y_in, de_in, hsync_in, vsync_in, rom_data,
        input  rom_addr, vga_r, vga_g, vga_b, vga_hsync, vga_vsync
    );

    modport slave (
        input  x_in, y_in, de_in, hsync_in, vsync_in, rom_data,
        output rom_addr, vga_r, vga_g, vga_b, vga_hsync, vga_vsync
    );
endinterface

// File: rtl/vga_img_pipe.sv
// 3-stage pixel pipeline: raster -> image ROM address -> palette -> RGB565,
// with sync re-alignment and a debounced key that cycles the display mode.
module vga_img_pipe #(
    parameter int unsigned H_ACT        = 800,
    parameter int unsigned V_ACT        = 600,
    parameter int unsigned IMG_W        = 400,
    parameter int unsigned IMG_H        = 300,
    parameter int unsigned DEBOUNCE_CYC = 800000,
    parameter bit          SYNC_POL     = 1'b1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             key,
    vga_img_pipe_if.slave    bus,
    output logic [1:0]       mode
);
    localparam logic [1:0]  MODE_STRETCH = 2'd0;
    localparam logic [1:0]  MODE_CENTRE  = 2'd1;
    localparam logic [1:0]  MODE_BARS    = 2'd2;
    localparam logic        SYNC_IDLE    = ~SYNC_POL;
    localparam logic [10:0] X0           = 11'((H_ACT - IMG_W) / 2);
    localparam logic [10:0] X1           = 11'((H_ACT - IMG_W) / 2 + IMG_W);
    localparam logic [10:0] Y0           = 11'((V_ACT - IMG_H) / 2);
    localparam logic [10:0] Y1           = 11'((V_ACT - IMG_H) / 2 + IMG_H);
    localparam int unsigned BAR_W        = H_ACT / 8;
    localparam int unsigned CW           = $clog2(DEBOUNCE_CYC + 1);

    logic [1:0]    mode_q, mode_d;

    // Stage 1: address generation
    logic [10:0]   row_c, col_c;
    logic [16:0]   addr_c;
    logic          in_img_c;
    logic [2:0]    bar_c;

    always_comb begin
        row_c    = '0;
        col_c    = '0;
        in_img_c = 1'b0;
        case (mode_q)
            MODE_STRETCH: begin
                in_img_c = bus.de_in;
                row_c    = {1'b0, bus.y_in[10:1]};
                col_c    = {1'b0, bus.x_in[10:1]};
            end
            MODE_CENTRE: begin
                in_img_c = bus.de_in && (bus.x_in >= X0) && (bus.x_in < X1)
                           && (bus.y_in >= Y0) && (bus.y_in < Y1);
                row_c    = bus.y_in - Y0;
                col_c    = bus.x_in - X0;
            end
            default: ;
        endcase
        // row*400 as a shift-add: 256 + 128 + 16
        addr_c = in_img_c ? (({6'b0, row_c} << 8) + ({6'b0, row_c} << 7)
                           + ({6'b0, row_c} << 4) + {6'b0, col_c}) : '0;

        bar_c = '0;
        for (int unsigned i = 1; i < 8; i++) begin
            if (bus.x_in >= 11'(i * BAR_W)) bar_c = bar_c + 3'd1;
        end
    end

    logic [16:0]   rom_addr_q;
    logic          in1_q, de1_q, bars1_q;
    logic [2:0]    bar1_q;
    logic          in2_q, de2_q, bars2_q;
    logic [2:0]    bar2_q;
    logic [2:0]    hs_q, vs_q;
    logic [4:0]    r_q, b_q;
    logic [5:0]    g_q;

    function automatic logic [4:0] lvl5(input logic [1:0] c);
        case (c)
            2'd0:    return 5'd0;
            2'd1:    return 5'd10;
            2'd2:    return 5'd21;
            default: return 5'd31;
        endcase
    endfunction

    function automatic logic [5:0] lvl6(input logic [1:0] c);
        case (c)
            2'd0:    return 6'd0;
            2'd1:    return 6'd21;
            2'd2:    return 6'd42;
            default: return 6'd63;
        endcase
    endfunction

    // Stage 3 input: ROM word (or bar index) and visibility after the read
    logic [3:0]    idx_c;
    logic          show_c;
    logic [4:0]    r_d, b_d;
    logic [5:0]    g_d;

    always_comb begin
        idx_c  = bars2_q ? {1'b1, bar2_q} : bus.rom_data;
        show_c = de2_q && (bars2_q || in2_q);
        r_d    = '0;
        g_d    = '0;
        b_d    = '0;
        if (show_c) begin
            r_d = lvl5({idx_c[2], idx_c[3]});
            g_d = lvl6({idx_c[1], idx_c[3]});
            b_d = lvl5({idx_c[0], idx_c[3]});
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rom_addr_q <= '0;
            in1_q      <= 1'b0;
            de1_q      <= 1'b0;
            bars1_q    <= 1'b0;
            bar1_q     <= '0;
            in2_q      <= 1'b0;
            de2_q      <= 1'b0;
            bars2_q    <= 1'b0;
            bar2_q     <= '0;
            hs_q       <= {3{SYNC_IDLE}};
            vs_q       <= {3{SYNC_IDLE}};
            r_q        <= '0;
            g_q        <= '0;
            b_q        <= '0;
        end else begin
            rom_addr_q <= addr_c;
            in1_q      <= in_img_c;
            de1_q      <= bus.de_in;
            bars1_q    <= (mode_q == MODE_BARS);
            bar1_q     <= bar_c;
            in2_q      <= in1_q;
            de2_q      <= de1_q;
            bars2_q    <= bars1_q;
            bar2_q     <= bar1_q;
            hs_q       <= {hs_q[1:0], bus.hsync_in};
            vs_q       <= {vs_q[1:0], bus.vsync_in};
            r_q        <= r_d;
            g_q        <= g_d;
            b_q        <= b_d;
        end
    end

    // Key: 2-FF synchroniser, then a run counter against the accepted level
    logic [1:0]    ks_q;
    logic          stable_q, stable_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic          pending_q, pending_d;
    logic          vs_prev_q;
    logic          press_c, commit_c;

    always_comb begin
        cnt_d    = '0;
        stable_d = stable_q;
        press_c  = 1'b0;
        if (ks_q[1] != stable_q) begin
            if (cnt_q == CW'(DEBOUNCE_CYC - 1)) begin
                stable_d = ks_q[1];
                press_c  = stable_q;
            end else begin
                cnt_d = cnt_q + CW'(1);
            end
        end
        commit_c = (bus.vsync_in == SYNC_POL) && (vs_prev_q != SYNC_POL);
        // A press landing on the commit edge waits for the next frame
        pending_d = commit_c ? (press_c & ~pending_q) : (pending_q | press_c);
        mode_d    = mode_q;
        if (commit_c && pending_q) begin
            mode_d = (mode_q == MODE_BARS) ? MODE_STRETCH : mode_q + 2'd1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ks_q      <= 2'b11;
            stable_q  <= 1'b1;
            cnt_q     <= '0;
            pending_q <= 1'b0;
            vs_prev_q <= SYNC_IDLE;
            mode_q    <= MODE_STRETCH;
        end else begin
            ks_q      <= {ks_q[0], key};
            stable_q  <= stable_d;
            cnt_q     <= cnt_d;
            pending_q <= pending_d;
            vs_prev_q <= bus.vsync_in;
            mode_q    <= mode_d;
        end
    end

    assign bus.rom_addr  = rom_addr_q;
    assign bus.vga_r     = r_q;
    assign bus.vga_g     = g_q;
    assign bus.vga_b     = b_q;
    assign bus.vga_hsync = hs_q[2];
    assign bus.vga_vsync = vs_q[2];
    assign mode          = mode_q;
endmodule

// File: tb/tb_vga_img_pipe.sv
// Randomised bench for vga_img_pipe against a frame-level reference model.
module tb_vga_img_pipe;
    localparam int unsigned DEB  = 16;
    localparam int unsigned NROM = 120000;

    logic       clk   = 1'b0;
    logic       rst_n = 1'b1;
    logic       key   = 1'b1;
    logic [1:0] mode;
    bit         vs_drv = 1'b0;
    bit         chk_on = 1'b0;
    int         n_tot  = 0;
    int         n_pass = 0;

    vga_img_pipe_if bus();

    vga_img_pipe #(
        .H_ACT(800), .V_ACT(600), .IMG_W(400), .IMG_H(300),
        .DEBOUNCE_CYC(DEB), .SYNC_POL(1'b1)
    ) dut (
        .clk(clk), .rst_n(rst_n), .key(key), .bus(bus), .mode(mode)
    );

    always #5 clk = ~clk;

    logic [3:0] rom [NROM];
    always @(posedge clk)
        bus.rom_data <= (bus.rom_addr < 17'(NROM)) ? rom[bus.rom_addr] : 4'd0;

    typedef struct packed {
        logic [16:0] addr;
        logic [4:0]  r;
        logic [5:0]  g;
        logic [4:0]  b;
        logic        hs;
        logic        vs;
    } exp_t;

    function automatic logic [15:0] pal(input logic [3:0] i);
        int lv5[4] = '{0, 10, 21, 31};
        int lv6[4] = '{0, 21, 42, 63};
        logic [4:0] r, b;
        logic [5:0] g;
        r = 5'(lv5[{i[2], i[3]}]);
        g = 6'(lv6[{i[1], i[3]}]);
        b = 5'(lv5[{i[0], i[3]}]);
        return {r, g, b};
    endfunction

    function automatic exp_t model_px(input int x, input int y, input bit de,
                                      input bit hs, input bit vs, input int m);
        exp_t t;
        bit in;
        int a, bar;
        logic [15:0] p;
        in = 1'b0; a = 0; p = '0;
        if (m == 0) begin
            in = de; a = (y / 2) * 400 + x / 2;
        end else if (m == 1) begin
            in = de && x >= 200 && x < 600 && y >= 150 && y < 450;
            a  = (y - 150) * 400 + (x - 200);
        end
        if (!in) a = 0;
        if (m == 2) begin
            bar = (x / 100 > 7) ? 7 : x / 100;
            if (de) p = pal(4'(8 + bar));
        end else if (in) begin
            p = pal(rom[a]);
        end
        t.addr = 17'(a);
        {t.r, t.g, t.b} = p;
        t.hs = hs;
        t.vs = vs;
        return t;
    endfunction

    // Reference model state
    exp_t e0, e1, e2;
    bit   kq[$];
    bit   sh[$];
    bit   stable_m, pending_m, vsp_m;
    int   mode_m;

    task automatic model_reset();
        e0 = '0; e1 = '0; e2 = '0;
        kq = '{1'b1, 1'b1};
        sh.delete();
        stable_m = 1'b1; pending_m = 1'b0; vsp_m = 1'b0; mode_m = 0;
    endtask

    task automatic model_step();
        exp_t t;
        bit s, press, all, commit, was;
        t  = model_px(int'(bus.x_in), int'(bus.y_in), bus.de_in, bus.hsync_in,
                      bus.vsync_in, mode_m);
        e2 = e1; e1 = e0; e0 = t;
        s = kq.pop_front();
        kq.push_back(key);
        sh.push_back(s);
        if (sh.size() > DEB) void'(sh.pop_front());
        press = 1'b0;
        if (sh.size() == DEB) begin
            all = 1'b1;
            foreach (sh[i]) if (sh[i] == stable_m) all = 1'b0;
            if (all) begin press = stable_m; stable_m = s; end
        end
        commit = bus.vsync_in && !vsp_m;
        vsp_m  = bus.vsync_in;
        was    = pending_m;
        if (commit) begin
            if (was) mode_m = (mode_m == 2) ? 0 : mode_m + 1;
            pending_m = 1'b0;
        end
        if (press && !was) pending_m = 1'b1;
    endtask

    initial begin
        model_reset();
        forever begin
            @(posedge clk or negedge rst_n);
            if (!rst_n) model_reset();
            else        model_step();
        end
    end

    task automatic cmp(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_tot++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0d expected %0d at %0t", nm, act, exp, $time);
    endtask

    initial begin
        forever begin
            @(negedge clk);
            if (chk_on) begin
                cmp("rom_addr", 32'(bus.rom_addr), 32'(e0.addr));
                cmp("rgb", 32'({bus.vga_r, bus.vga_g, bus.vga_b}), 32'({e2.r, e2.g, e2.b}));
                cmp("sync", 32'({bus.vga_hsync, bus.vga_vsync}), 32'({e2.hs, e2.vs}));
                cmp("mode", 32'(mode), 32'(mode_m));
            end
        end
    end

    task automatic px(input int x, input int y, input bit de, input bit hs);
        @(negedge clk);
        bus.x_in     = 11'(x);
        bus.y_in     = 11'(y);
        bus.de_in    = de;
        bus.hsync_in = hs;
        bus.vsync_in = vs_drv;
    endtask

    task automatic idle(input int n);
        repeat (n) px(0, 0, 1'b0, 1'b0);
    endtask

    task automatic rnd_px();
        int x, y;
        bit de;
        x  = int'($urandom_range(0, 899));
        y  = int'($urandom_range(0, 659));
        de = (x < 800) && (y < 600) && ($urandom_range(0, 3) != 0);
        px(x, y, de, 1'($urandom_range(0, 1)));
    endtask

    task automatic run_rand(input int n);
        repeat (n) rnd_px();
    endtask

    task automatic probe(input string nm, input int x, input int y,
                         input int exp_addr, input logic [15:0] exp_rgb);
        px(x, y, 1'b1, 1'b0);
        px(0, 0, 1'b0, 1'b0);
        cmp({nm, "_addr"}, 32'(bus.rom_addr), 32'(exp_addr));
        idle(2);
        cmp({nm, "_rgb"}, 32'({bus.vga_r, bus.vga_g, bus.vga_b}), 32'(exp_rgb));
    endtask

    task automatic press_key(input int hold);
        repeat (hold) begin rnd_px(); key = 1'b0; end
        repeat (40)   begin rnd_px(); key = 1'b1; end
    endtask

    task automatic vs_pulse();
        vs_drv = 1'b1; run_rand(4);
        vs_drv = 1'b0; run_rand(4);
    endtask

    initial begin
        int seg;
        for (int i = 0; i < int'(NROM); i++) rom[i] = 4'($urandom);
        rom[801]    = 4'hC;
        rom[0]      = 4'hF;
        rom[119999] = 4'h9;
        bus.x_in = '0; bus.y_in = '0; bus.de_in = 1'b0;
        bus.hsync_in = 1'b0; bus.vsync_in = 1'b0;

        #3 rst_n = 1'b0;
        chk_on = 1'b1;
        #1;
        cmp("reset_addr", 32'(bus.rom_addr), 32'd0);
        cmp("reset_rgb", 32'({bus.vga_r, bus.vga_g, bus.vga_b}), 32'd0);
        cmp("reset_sync", 32'({bus.vga_hsync, bus.vga_vsync}), 32'd0);
        cmp("reset_mode", 32'(mode), 32'd0);
        repeat (3) @(negedge clk);
        rst_n = 1'b1;

        // Mode 0: (3,5) -> row 2, col 1 -> 801; hsync seen exactly 3 cycles on
        px(3, 5, 1'b1, 1'b1);
        px(0, 0, 1'b0, 1'b0);
        cmp("m0_addr_3_5", 32'(bus.rom_addr), 32'd801);
        px(0, 0, 1'b0, 1'b0);
        cmp("hsync_not_early", 32'(bus.vga_hsync), 32'd0);
        px(0, 0, 1'b0, 1'b0);
        cmp("m0_rgb_C", 32'({bus.vga_r, bus.vga_g, bus.vga_b}), 32'({5'd31, 6'd21, 5'd10}));
        cmp("hsync_3cyc", 32'(bus.vga_hsync), 32'd1);
        probe("m0_corner", 799, 599, 119999, {5'd10, 6'd21, 5'd31});
        px(799, 599, 1'b0, 1'b0);
        px(0, 0, 1'b0, 1'b0);
        cmp("m0_de0_addr", 32'(bus.rom_addr), 32'd0);
        run_rand(1500);

        // Bouncy press then a long hold: one press, committed at vsync only
        repeat (5) begin
            repeat ($urandom_range(1, DEB - 4)) begin rnd_px(); key = 1'b0; end
            repeat ($urandom_range(1, 5))       begin rnd_px(); key = 1'b1; end
        end
        press_key(100);
        cmp("mode_before_vsync", 32'(mode), 32'd0);
        vs_pulse();
        cmp("mode_after_commit1", 32'(mode), 32'd1);

        probe("m1_origin", 200, 150, 0, {5'd31, 6'd63, 5'd31});
        probe("m1_x199", 199, 150, 0, 16'd0);
        probe("m1_corner", 599, 449, 119999, {5'd10, 6'd21, 5'd31});
        probe("m1_x600", 600, 449, 0, 16'd0);
        probe("m1_y450", 599, 450, 0, 16'd0);
        run_rand(1500);

        // Two presses in one frame advance the mode once
        press_key(30);
        press_key(30);
        vs_pulse();
        cmp("mode_double_press", 32'(mode), 32'd2);

        probe("bar_x0", 0, 10, 0, {5'd10, 6'd21, 5'd10});
        probe("bar_x99", 99, 10, 0, {5'd10, 6'd21, 5'd10});
        probe("bar_x100", 100, 10, 0, {5'd10, 6'd21, 5'd31});
        probe("bar_x799", 799, 10, 0, {5'd31, 6'd63, 5'd31});
        run_rand(1000);

        press_key(30);
        vs_pulse();
        cmp("mode_wrap", 32'(mode), 32'd0);
        repeat (2) begin press_key(30); vs_pulse(); end
        cmp("mode_back_to_bars", 32'(mode), 32'd2);

        // Asynchronous reset in the middle of a bars line
        repeat (5) px(400, 300, 1'b1, 1'b1);
        @(posedge clk);
        #2 rst_n = 1'b0;
        #1;
        cmp("midreset_rgb", 32'({bus.vga_r, bus.vga_g, bus.vga_b}), 32'd0);
        cmp("midreset_sync", 32'({bus.vga_hsync, bus.vga_vsync}), 32'd0);
        cmp("midreset_mode", 32'(mode), 32'd0);
        cmp("midreset_addr", 32'(bus.rom_addr), 32'd0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        run_rand(500);
        cmp("mode_after_reset", 32'(mode), 32'd0);

        // Random key activity against random vsync pulses
        seg = 0;
        for (int i = 0; i < 4000; i++) begin
            vs_drv = ((i % 97) < 4);
            if (seg == 0) begin
                key = ~key;
                seg = int'($urandom_range(1, 45));
            end
            seg--;
            rnd_px();
        end
        key = 1'b1;
        vs_drv = 1'b0;
        run_rand(50);

        $display("%0d/%0d checks passed", n_pass, n_tot);
        $finish;
    end
endmodule
